hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage core. It watches the instruction in decode (ID) and the instruction in execute (EX), and drives the control for PC, the IF/ID buffer and the ID/EX buffer. Those controls are hold, flush, bubble and immediate-phase. It sequences three cases: load-use stalls, two-word (immediate) instructions and taken-branch flushes. It sits beside the decoder, and its `make_bubble` output feeds the ID/EX buffer's bubble input.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubble cycles inserted per load-use hazard (1..7).
- `FLUSH_CYCLES`, default 2: cycles IF/ID is flushed after a taken branch (1..7).
- `NO_REG`, default 4'b1111: register address meaning "no register / bubble".
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_src_addr` in 4: source register of the ID instruction.
- `id_dst_addr` in 4: destination register of the ID instruction.
- `id_uses_src`, `id_uses_dst` in 1: the ID instruction reads that register.
- `id_two_word` in 1: the ID instruction is the first word of a two-word instruction.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_dest_addr` in 4: destination register of the EX instruction.
- `ex_is_bubble` in 1: the EX slot holds a bubble.
- `branch_taken` in 1: EX resolved a taken branch this cycle.
- `pc_hold` out 1: PC keeps its value.
- `ifid_hold` out 1: IF/ID keeps its contents.
- `ifid_flush` out 1: IF/ID loads a NOP.
- `make_bubble` out 1: ID/EX captures a bubble.
- `imm_phase` out 1: the IF/ID word is the immediate of the pending two-word instruction.
- `state` out 2: current FSM state, for debug.
- `stall_count` out 16: saturating count of cycles with `make_bubble`=1.

## Operation
- FSM states: RUN=0, LOAD_STALL=1, IMM=2, FLUSH=3. A 3-bit down-counter `cnt` serves LOAD_STALL and FLUSH.
- Load-use hazard (`lu`) holds when all of these are true:
  - `ex_mem_read` = 1 and `ex_is_bubble` = 0 and `ex_dest_addr` ≠ `NO_REG`;
  - and either (`id_uses_src` and `id_src_addr` == `ex_dest_addr`) or (`id_uses_dst` and `id_dst_addr` == `ex_dest_addr`).
- Outputs are Mealy: they depend on the state and the current inputs in the same cycle.
- Priority in every state: `branch_taken` > `lu` > `id_two_word`.
- `branch_taken` (any state):
  - `ifid_flush`=1, `make_bubble`=1, `pc_hold`=0.
  - If `FLUSH_CYCLES`>1: next state FLUSH, `cnt`=`FLUSH_CYCLES`-2. Otherwise next state RUN.
  - Aborts any pending LOAD_STALL or IMM.
- RUN:
  - On `lu`: `pc_hold`=`ifid_hold`=`make_bubble`=1. If `LOAD_STALL_CYCLES`>1: next state LOAD_STALL, `cnt`=`LOAD_STALL_CYCLES`-2; else remain in RUN (the hazard is re-evaluated).
  - Else if `id_two_word`: `make_bubble`=1 (the first word is not issued alone); next state IMM.
  - Else all outputs 0.
- LOAD_STALL: `pc_hold`=`ifid_hold`=`make_bubble`=1. When `cnt`==0, next state RUN; otherwise `cnt` decrements.
- IMM:
  - `imm_phase`=1, `make_bubble`=0 (the combined instruction issues). Next state RUN.
  - `lu` is ignored in IMM: the immediate word has no register operands.
- FLUSH: `ifid_flush`=1, `make_bubble`=1. When `cnt`==0, next state RUN; otherwise `cnt` decrements.
- `stall_count` increments on each clock edge where `make_bubble`=1 and saturates at 16'hFFFF.

## Timing
- Reset (asynchronous, while `rst`=1):
  - state=RUN, `cnt`=0, `stall_count`=0.
  - `make_bubble`=1. `pc_hold`, `ifid_hold`, `ifid_flush` and `imm_phase` are all 0.
  - `stall_count` does not increment while in reset.
- Latency: hazard-to-control is combinational (0 cycles); state changes take effect on the next rising `clk`.
- A load-use stall lasts exactly `LOAD_STALL_CYCLES` cycles, unless a branch interrupts it.
- A flush lasts exactly `FLUSH_CYCLES` cycles, counting the `branch_taken` cycle.
- A two-word instruction occupies exactly 2 ID cycles: one bubble, then `imm_phase`.
- `branch_taken` during FLUSH restarts the flush count.
- Reset asserted mid-stall or mid-IMM returns to RUN immediately; no partial state survives.

## Structure
- Shared package `hazard_pkg`: state enum (RUN, LOAD_STALL, IMM, FLUSH), `NO_REG` constant, `REG_ADDR_W`=4.
- Single module with no sub-modules. The `lu` comparator is an internal function.

## Test plan
- Load-use hazard:
  - Stimulus: EX load to r3 (`ex_mem_read`=1, `ex_dest_addr`=3); ID reads r3 (`id_uses_src`=1, `id_src_addr`=3); `LOAD_STALL_CYCLES`=1.
  - Required: exactly 1 cycle with `pc_hold`=`ifid_hold`=`make_bubble`=1, then all outputs 0 once EX shows a bubble.
- No false hazard: EX load with `ex_dest_addr`=4'hF, or `ex_is_bubble`=1, with matching ID addresses -> no stall, `stall_count` unchanged.
- Two-word instruction: `id_two_word`=1 in RUN -> cycle 0 `make_bubble`=1; cycle 1 `imm_phase`=1, state=IMM; cycle 2 state=RUN.
- Branch during IMM: `branch_taken`=1 in IMM with `FLUSH_CYCLES`=2 -> `ifid_flush`=1 for 2 cycles, `imm_phase`=0, then RUN.
- Branch plus load-use in the same cycle -> flush wins: `ifid_flush`=1, `pc_hold`=0.
- Reset and saturation:
  - Assert `rst` mid LOAD_STALL (`LOAD_STALL_CYCLES`=3) -> state=0 and `stall_count`=0 immediately.
  - Preload `stall_count` near 16'hFFFF -> it holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Brief    : Shared types and constants for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Width of a register-file address.
    localparam int REG_ADDR_W = 4;

    // Register address reserved to mean "no register / bubble".
    localparam logic [REG_ADDR_W-1:0] NO_REG = 4'b1111;

    // Width of the stall/flush down-counter.
    localparam int CNT_W = 3;

    // Width of the saturating bubble counter.
    localparam int STALL_CNT_W = 16;

    // Controller states; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        IMM        = 2'd2,
        FLUSH      = 2'd3
    } hz_state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_if
//  Brief    : Decode/execute observation and pipeline-control bundle between
//             the core datapath (master) and the hazard controller (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    import hazard_pkg::*;

    // Instruction in decode
    logic [REG_ADDR_W-1:0]  id_src_addr;
    logic [REG_ADDR_W-1:0]  id_dst_addr;
    logic                   id_uses_src;
    logic                   id_uses_dst;
    logic                   id_two_word;

    // Instruction in execute
    logic                   ex_mem_read;
    logic [REG_ADDR_W-1:0]  ex_dest_addr;
    logic                   ex_is_bubble;
    logic                   branch_taken;

    // Pipeline controls
    logic                   pc_hold;
    logic                   ifid_hold;
    logic                   ifid_flush;
    logic                   make_bubble;
    logic                   imm_phase;

    // Debug / statistics
    logic [1:0]             state;
    logic [STALL_CNT_W-1:0] stall_count;

    // Datapath side: reports ID/EX contents, consumes the controls.
    modport master (
        output id_src_addr, id_dst_addr, id_uses_src, id_uses_dst, id_two_word,
        output ex_mem_read, ex_dest_addr, ex_is_bubble, branch_taken,
        input  pc_hold, ifid_hold, ifid_flush, make_bubble, imm_phase,
        input  state, stall_count
    );

    // Controller side.
    modport slave (
        input  id_src_addr, id_dst_addr, id_uses_src, id_uses_dst, id_two_word,
        input  ex_mem_read, ex_dest_addr, ex_is_bubble, branch_taken,
        output pc_hold, ifid_hold, ifid_flush, make_bubble, imm_phase,
        output state, stall_count
    );

endinterface : hazard_ctrl_if
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Brief    : Pipeline hazard and stall controller for the five-stage core.
//             Sequences load-use stalls, two-word (immediate) instructions and
//             taken-branch flushes. Controls are Mealy: they react to the
//             current ID/EX contents in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter logic [hazard_pkg::REG_ADDR_W-1:0] NO_REG = hazard_pkg::NO_REG
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hazard_ctrl_if.slave bus
);
    import hazard_pkg::*;

    // Counter reload values. The "-2" accounts for the entry cycle (spent in
    // RUN or on the branch) plus the final cycle at count zero.
    localparam logic [CNT_W-1:0] C_STALL_RELOAD =
        (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;
    localparam logic [CNT_W-1:0] C_FLUSH_RELOAD =
        (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
    localparam bit C_STALL_MULTI = (LOAD_STALL_CYCLES > 1);
    localparam bit C_FLUSH_MULTI = (FLUSH_CYCLES > 1);
    localparam logic [STALL_CNT_W-1:0] C_STALL_CNT_MAX = '1;

    // ------------------------------------------------------------------------
    // Load-use comparator: a live load in EX writes a register that the
    // instruction in ID reads (or read-modify-writes via its destination).
    // ------------------------------------------------------------------------
    function automatic logic f_load_use(
        input logic                  mem_read,
        input logic                  ex_bubble,
        input logic [REG_ADDR_W-1:0] ex_dst,
        input logic                  uses_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  uses_dst,
        input logic [REG_ADDR_W-1:0] dst
    );
        logic live_load;
        logic src_hit;
        logic dst_hit;
        live_load = mem_read && !ex_bubble && (ex_dst != NO_REG);
        src_hit   = uses_src && (src == ex_dst);
        dst_hit   = uses_dst && (dst == ex_dst);
        return live_load && (src_hit || dst_hit);
    endfunction

    hz_state_e               r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [STALL_CNT_W-1:0]  r_stall_count;

    hz_state_e               w_state_nxt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    w_lu;
    logic                    w_pc_hold;
    logic                    w_ifid_hold;
    logic                    w_ifid_flush;
    logic                    w_make_bubble;
    logic                    w_imm_phase;

    assign w_lu = f_load_use(bus.ex_mem_read, bus.ex_is_bubble, bus.ex_dest_addr,
                             bus.id_uses_src, bus.id_src_addr,
                             bus.id_uses_dst, bus.id_dst_addr);

    // Next-state and control decode; branch beats load-use beats two-word.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_make_bubble = 1'b0;
        w_imm_phase   = 1'b0;

        if (bus.branch_taken) begin
            // A taken branch kills whatever was in flight, including a
            // pending immediate word or an unfinished load stall.
            w_ifid_flush  = 1'b1;
            w_make_bubble = 1'b1;
            if (C_FLUSH_MULTI) begin
                w_state_nxt = FLUSH;
                w_cnt_nxt   = C_FLUSH_RELOAD;
            end else begin
                w_state_nxt = RUN;
            end
        end else begin
            case (r_state)
                RUN: begin
                    if (w_lu) begin
                        w_pc_hold     = 1'b1;
                        w_ifid_hold   = 1'b1;
                        w_make_bubble = 1'b1;
                        if (C_STALL_MULTI) begin
                            w_state_nxt = LOAD_STALL;
                            w_cnt_nxt   = C_STALL_RELOAD;
                        end
                    end else if (bus.id_two_word) begin
                        // First word waits for its immediate before issuing.
                        w_make_bubble = 1'b1;
                        w_state_nxt   = IMM;
                    end
                end

                LOAD_STALL: begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_make_bubble = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end

                IMM: begin
                    // The immediate word carries no register operands, so a
                    // load-use match here is meaningless and ignored.
                    w_imm_phase = 1'b1;
                    w_state_nxt = RUN;
                end

                FLUSH: begin
                    w_ifid_flush  = 1'b1;
                    w_make_bubble = 1'b1;
                    if (r_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - 1'b1;
                    end
                end

                default: begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // State, counter and bubble statistics register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= RUN;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_make_bubble && (r_stall_count != C_STALL_CNT_MAX)) begin
                r_stall_count <= r_stall_count + 1'b1;
            end
        end
    end

    // While reset is held the pipeline sees a bubble and no other control,
    // regardless of what ID/EX currently contain.
    assign bus.pc_hold     = !rst && w_pc_hold;
    assign bus.ifid_hold   = !rst && w_ifid_hold;
    assign bus.ifid_flush  = !rst && w_ifid_flush;
    assign bus.imm_phase   = !rst && w_imm_phase;
    assign bus.make_bubble =  rst || w_make_bubble;
    assign bus.state       = r_state;
    assign bus.stall_count = r_stall_count;

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl
//  Brief    : Self-checking bench for hazard_ctrl. Two instances (load stall
//             of 1 and 3 cycles, flush of 2) share one directed stimulus;
//             a remaining-cycles model predicts every output each cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] id_src_addr  = '0;
    logic [3:0] id_dst_addr  = '0;
    logic       id_uses_src  = 1'b0;
    logic       id_uses_dst  = 1'b0;
    logic       id_two_word  = 1'b0;
    logic       ex_mem_read  = 1'b0;
    logic [3:0] ex_dest_addr = '0;
    logic       ex_is_bubble = 1'b0;
    logic       branch_taken = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_if ifa ();
    hazard_ctrl_if ifb ();

    assign ifa.id_src_addr  = id_src_addr;   assign ifb.id_src_addr  = id_src_addr;
    assign ifa.id_dst_addr  = id_dst_addr;   assign ifb.id_dst_addr  = id_dst_addr;
    assign ifa.id_uses_src  = id_uses_src;   assign ifb.id_uses_src  = id_uses_src;
    assign ifa.id_uses_dst  = id_uses_dst;   assign ifb.id_uses_dst  = id_uses_dst;
    assign ifa.id_two_word  = id_two_word;   assign ifb.id_two_word  = id_two_word;
    assign ifa.ex_mem_read  = ex_mem_read;   assign ifb.ex_mem_read  = ex_mem_read;
    assign ifa.ex_dest_addr = ex_dest_addr;  assign ifb.ex_dest_addr = ex_dest_addr;
    assign ifa.ex_is_bubble = ex_is_bubble;  assign ifb.ex_is_bubble = ex_is_bubble;
    assign ifa.branch_taken = branch_taken;  assign ifb.branch_taken = branch_taken;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .NO_REG(4'hF)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .NO_REG(4'hF)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    // ---------------- model: remaining cycles of each activity -------------
    int lsc [2] = '{1, 3};
    int fc  [2] = '{2, 2};
    int m_stall_left [2];   // further stall cycles after the current one
    int m_flush_left [2];   // further flush cycles after the current one
    bit m_imm        [2];   // immediate word sits in IF/ID now
    int m_count      [2];

    function automatic bit model_lu();
        return ex_mem_read && !ex_is_bubble && (ex_dest_addr != 4'hF) &&
               ((id_uses_src && id_src_addr == ex_dest_addr) ||
                (id_uses_dst && id_dst_addr == ex_dest_addr));
    endfunction

    // {pc_hold, ifid_hold, ifid_flush, make_bubble, imm_phase} out of reset
    function automatic logic [4:0] exp_ctrl(input int k);
        if (branch_taken)          return 5'b00110;
        if (m_flush_left[k] > 0)   return 5'b00110;
        if (m_stall_left[k] > 0)   return 5'b11010;
        if (m_imm[k])              return 5'b00001;
        if (model_lu())            return 5'b11010;
        if (id_two_word)           return 5'b00010;
        return 5'b00000;
    endfunction

    function automatic logic [1:0] exp_state(input int k);
        if (m_flush_left[k] > 0) return 2'd3;
        if (m_stall_left[k] > 0) return 2'd1;
        if (m_imm[k])            return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_stall_left[k] = 0;
            m_flush_left[k] = 0;
            m_imm[k]        = 1'b0;
            m_count[k]      = 0;
        end
    endtask

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < 2; k++) begin
                logic [4:0] e;
                e = exp_ctrl(k);
                if (e[1] && m_count[k] < 65535) m_count[k]++;
                if (branch_taken) begin
                    m_flush_left[k] = fc[k] - 1;
                    m_stall_left[k] = 0;
                    m_imm[k]        = 1'b0;
                end else if (m_flush_left[k] > 0) begin
                    m_flush_left[k]--;
                end else if (m_stall_left[k] > 0) begin
                    m_stall_left[k]--;
                end else if (m_imm[k]) begin
                    m_imm[k] = 1'b0;
                end else if (model_lu()) begin
                    m_stall_left[k] = lsc[k] - 1;
                end else if (id_two_word) begin
                    m_imm[k] = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (rst) model_clear();
        for (int k = 0; k < 2; k++) begin
            logic [4:0]  e;
            logic [1:0]  es;
            logic [4:0]  a;
            logic [1:0]  as_;
            logic [15:0] ac;
            string       p;
            p = (k == 0) ? "a" : "b";
            if (k == 0) begin
                a   = {ifa.pc_hold, ifa.ifid_hold, ifa.ifid_flush, ifa.make_bubble, ifa.imm_phase};
                as_ = ifa.state;
                ac  = ifa.stall_count;
            end else begin
                a   = {ifb.pc_hold, ifb.ifid_hold, ifb.ifid_flush, ifb.make_bubble, ifb.imm_phase};
                as_ = ifb.state;
                ac  = ifb.stall_count;
            end
            e  = rst ? 5'b00010 : exp_ctrl(k);
            es = rst ? 2'd0 : exp_state(k);
            chk({p, ".ctrl"},        16'(a),  16'(e));
            chk({p, ".state"},       16'(as_), 16'(es));
            chk({p, ".stall_count"}, ac, 16'(m_count[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src_addr = '0; id_dst_addr = '0; id_uses_src = 0; id_uses_dst = 0;
        id_two_word = 0; ex_mem_read = 0; ex_dest_addr = '0; ex_is_bubble = 0;
        branch_taken = 0;
    endtask

    task automatic set_load_use_r3();
        ex_mem_read = 1; ex_dest_addr = 4'd3; ex_is_bubble = 0;
        id_uses_src = 1; id_src_addr = 4'd3;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        #1;
        chk("rst.make_bubble", 16'(ifa.make_bubble), 16'd1);
        chk("rst.pc_hold",     16'(ifa.pc_hold),     16'd0);
        chk("rst.state",       16'(ifa.state),       16'd0);
        chk("rst.stall_count", ifa.stall_count,      16'd0);
        tick(); rst = 0;
        tick();

        // Load-use, 1-cycle (a) and 3-cycle (b)
        set_load_use_r3();
        #1;
        chk("lu.a.pc_hold",     16'(ifa.pc_hold),     16'd1);
        chk("lu.a.ifid_hold",   16'(ifa.ifid_hold),   16'd1);
        chk("lu.a.make_bubble", 16'(ifa.make_bubble), 16'd1);
        chk("lu.b.pc_hold",     16'(ifb.pc_hold),     16'd1);
        tick();
        ex_is_bubble = 1;
        #1;
        chk("lu.a.release",     16'(ifa.pc_hold),     16'd0);
        chk("lu.a.bubble_off",  16'(ifa.make_bubble), 16'd0);
        chk("lu.a.count",       ifa.stall_count,      16'd1);
        chk("lu.b.state",       16'(ifb.state),       16'd1);
        tick(); tick(); tick();
        chk("lu.b.count",       ifb.stall_count,      16'd3);
        chk("lu.b.done",        16'(ifb.state),       16'd0);

        // No false hazard
        ex_is_bubble = 0; ex_dest_addr = 4'hF; id_src_addr = 4'hF;
        #1;
        chk("nf.noreg.pc_hold", 16'(ifa.pc_hold), 16'd0);
        tick();
        ex_dest_addr = 4'd3; id_src_addr = 4'd3; ex_is_bubble = 1;
        #1;
        chk("nf.bubble.make_bubble", 16'(ifb.make_bubble), 16'd0);
        tick();
        chk("nf.a.count", ifa.stall_count, 16'd1);
        chk("nf.b.count", ifb.stall_count, 16'd3);
        clear_inputs();

        // Two-word instruction
        id_two_word = 1;
        #1;
        chk("tw.c0.make_bubble", 16'(ifa.make_bubble), 16'd1);
        tick();
        id_two_word = 0;
        #1;
        chk("tw.c1.imm_phase", 16'(ifa.imm_phase), 16'd1);
        chk("tw.c1.state",     16'(ifa.state),     16'd2);
        tick();
        chk("tw.c2.state",     16'(ifa.state),     16'd0);

        // Branch during IMM
        id_two_word = 1;
        tick();
        id_two_word = 0; branch_taken = 1;
        #1;
        chk("bi.flush",     16'(ifa.ifid_flush), 16'd1);
        chk("bi.imm_phase", 16'(ifa.imm_phase),  16'd0);
        tick();
        branch_taken = 0;
        #1;
        chk("bi.c1.flush",  16'(ifa.ifid_flush), 16'd1);
        chk("bi.c1.state",  16'(ifa.state),      16'd3);
        tick();
        chk("bi.c2.flush",  16'(ifa.ifid_flush), 16'd0);
        chk("bi.c2.state",  16'(ifa.state),      16'd0);

        // Branch and load-use together
        set_load_use_r3(); branch_taken = 1;
        #1;
        chk("bl.a.flush",   16'(ifa.ifid_flush), 16'd1);
        chk("bl.a.pc_hold", 16'(ifa.pc_hold),    16'd0);
        chk("bl.b.pc_hold", 16'(ifb.pc_hold),    16'd0);
        tick();
        branch_taken = 0; ex_is_bubble = 1;
        tick(); tick();
        clear_inputs();

        // Reset mid LOAD_STALL
        set_load_use_r3();
        tick();
        ex_is_bubble = 1;
        #1;
        chk("rs.b.in_stall", 16'(ifb.state), 16'd1);
        rst = 1;
        #1;
        chk("rs.b.state",       16'(ifb.state),       16'd0);
        chk("rs.b.count",       ifb.stall_count,      16'd0);
        chk("rs.b.pc_hold",     16'(ifb.pc_hold),     16'd0);
        chk("rs.b.make_bubble", 16'(ifb.make_bubble), 16'd1);
        tick();
        rst = 0;
        clear_inputs();
        tick();

        // Saturation under a continuous branch stream (also restarts flush)
        branch_taken = 1;
        for (int i = 0; i < 65540; i++) tick();
        chk("sat.a.count", ifa.stall_count, 16'hFFFF);
        chk("sat.b.count", ifb.stall_count, 16'hFFFF);
        chk("sat.a.state", 16'(ifa.state),  16'd3);
        branch_taken = 0;
        #1;
        chk("sat.tail.flush", 16'(ifa.ifid_flush), 16'd1);
        tick();
        chk("sat.end.state",  16'(ifa.state),      16'd0);
        chk("sat.end.count",  ifa.stall_count,     16'hFFFF);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire
